// File: rtl/jtdsp16_ext_ctrl.sv
// DSP16 external-memory responder: turns ext_rq/ext_ok stalls into cs/ok bus cycles,
// with a one-entry read buffer and a memory-acknowledge timeout guard.
module jtdsp16_ext_ctrl #(
    parameter int AW   = 16,
    parameter int DW   = 16,
    parameter int TOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ext_rq,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_dout,
    output logic [DW-1:0] ext_din,
    output logic          ext_ok,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ok,
    output logic          err
);

    localparam int CW = (TOUT > 0) ? $clog2(TOUT + 1) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state;
    logic          done_vld;
    logic [AW-1:0] done_addr;
    logic          done_we;
    logic          buf_vld;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_data;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          buf_hit;
    logic          tout_hit;

    // ext_ok must drop the instant address or direction moves away from the tag
    assign ext_ok   = ext_rq & done_vld & (ext_addr == done_addr) & (ext_we == done_we);
    assign buf_hit  = !ext_we && buf_vld && (buf_addr == ext_addr);
    assign cnt_nxt  = (cnt == CW'(TOUT)) ? cnt : cnt + 1'b1;
    assign tout_hit = (TOUT != 0) && (cnt == CW'(TOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ext_din   <= '0;
            err       <= 1'b0;
            done_vld  <= 1'b0;
            done_addr <= '0;
            done_we   <= 1'b0;
            buf_vld   <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
            cnt       <= '0;
        end else begin
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!ext_rq) begin
                        done_vld <= 1'b0;
                    end else if (!ext_ok) begin
                        if (buf_hit) begin
                            ext_din   <= buf_data;
                            done_vld  <= 1'b1;
                            done_addr <= ext_addr;
                            done_we   <= 1'b0;
                        end else begin
                            mem_cs    <= 1'b1;
                            mem_we    <= ext_we;
                            mem_addr  <= ext_addr;
                            mem_wdata <= ext_dout;
                            done_vld  <= 1'b0;
                            cnt       <= '0;
                            state     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt_nxt;
                    // an acknowledge in the timeout cycle still completes normally
                    if (mem_ok || tout_hit) begin
                        mem_cs    <= 1'b0;
                        mem_we    <= 1'b0;
                        done_vld  <= 1'b1;
                        done_addr <= mem_addr;
                        done_we   <= mem_we;
                        state     <= IDLE;
                    end
                    if (mem_ok) begin
                        if (!mem_we) begin
                            ext_din  <= mem_rdata;
                            buf_vld  <= 1'b1;
                            buf_addr <= mem_addr;
                            buf_data <= mem_rdata;
                        end else if (buf_addr == mem_addr) begin
                            buf_data <= mem_wdata;
                        end
                    end else if (tout_hit) begin
                        ext_din <= '1;
                        err     <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtdsp16_ext_ctrl.sv
// Randomised transaction-level check of jtdsp16_ext_ctrl against a behavioural
// model of memory, read buffer, latency and timeout.
module tb_jtdsp16_ext_ctrl;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int TOUT = 8;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ext_rq = 1'b0;
    logic          ext_we = 1'b0;
    logic [AW-1:0] ext_addr = '0;
    logic [DW-1:0] ext_dout = '0;
    logic [DW-1:0] ext_din;
    logic          ext_ok;
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ok = 1'b0;
    logic          err;

    jtdsp16_ext_ctrl #(.AW(AW), .DW(DW), .TOUT(TOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ext_rq(ext_rq), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_dout(ext_dout), .ext_din(ext_din), .ext_ok(ext_ok),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ok(mem_ok),
        .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // bus-side memory and the model's view of memory
    logic [DW-1:0] mem     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];

    int cur_lat = 0;
    int cyc = 0;
    int bus_starts = 0;
    int cs_cycles = 0;
    int err_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (mem_cs) begin
                if (cyc == 0) bus_starts++;
                cs_cycles++;
                if (cyc == cur_lat) begin
                    mem_ok = 1'b1;
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    else        mem_rdata = mem[mem_addr];
                end else begin
                    mem_ok = 1'b0;
                    mem_rdata = DW'($urandom);
                end
                cyc++;
            end else begin
                mem_ok = 1'b0;
                cyc = 0;
            end
            if (err) err_cnt++;
        end
    end

    // model state
    logic          m_bv = 1'b0;
    logic [AW-1:0] m_ba = '0;
    logic [DW-1:0] m_bd = '0;
    logic [DW-1:0] m_din = '0;
    int e_cyc, e_bus, e_cs, e_err;
    int s_bus, s_cs, s_err;

    task automatic start_access(input logic [AW-1:0] a, input logic we,
                                input logic [DW-1:0] d, input int lat);
        cur_lat = lat;
        if (!we && m_bv && m_ba == a) begin
            e_bus = 0; e_cs = 0; e_err = 0; e_cyc = 1;
            m_din = m_bd;
        end else if (lat >= TOUT) begin
            e_bus = 1; e_cs = TOUT; e_err = 1; e_cyc = TOUT + 1;
            m_din = '1;
        end else begin
            e_bus = 1; e_cs = lat + 1; e_err = 0; e_cyc = lat + 2;
            if (we) begin
                ref_mem[a] = d;
                if (m_ba == a) m_bd = d;
            end else begin
                m_din = ref_mem[a];
                m_bv = 1'b1; m_ba = a; m_bd = ref_mem[a];
            end
        end
        s_bus = bus_starts; s_cs = cs_cycles; s_err = err_cnt;
        ext_rq = 1'b1; ext_we = we; ext_addr = a; ext_dout = d;
    endtask

    task automatic finish_access(input bit drop);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ext_ok && n < 40);
        chk("ok_latency", n, e_cyc);
        chk("ext_din", ext_din, m_din);
        chk("bus_cycles", bus_starts - s_bus, e_bus);
        chk("cs_high", cs_cycles - s_cs, e_cs);
        @(posedge clk); #1;
        chk("ok_hold", ext_ok, 1);
        chk("err_pulses", err_cnt - s_err, e_err);
        chk("err_low", err, 0);
        if (drop) begin
            @(negedge clk);
            ext_rq = 1'b0;
            #1 chk("ok_drop", ext_ok, 0);
            @(posedge clk);
        end
    endtask

    task automatic access(input logic [AW-1:0] a, input logic we,
                          input logic [DW-1:0] d, input int lat);
        @(negedge clk);
        start_access(a, we, d, lat);
        finish_access(1'b1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = DW'(i) ^ 16'h5a5a;
            ref_mem[i] = mem[i];
        end
        mem[16'h0123] = 16'hBEEF;
        ref_mem[16'h0123] = 16'hBEEF;

        // request held through reset
        start_access(16'h0123, 1'b0, '0, 3);
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_cs", mem_cs, 0);
        end
        chk("rst_ok", ext_ok, 0);
        chk("rst_err", err, 0);
        chk("rst_din", ext_din, 0);
        @(negedge clk);
        rst_n = 1'b1;
        finish_access(1'b1);

        access(16'h0123, 1'b0, '0, 3);
        access(16'h0123, 1'b1, 16'h1234, 2);
        access(16'h0123, 1'b0, '0, 4);
        access(16'h0200, 1'b0, '0, NEVER);
        access(16'h0201, 1'b1, 16'h7777, NEVER);
        access(16'h0202, 1'b0, '0, TOUT - 1);
        access(16'h0203, 1'b0, '0, 0);

        // address moves while ext_ok is high
        @(negedge clk);
        start_access(16'h0010, 1'b0, '0, 1);
        finish_access(1'b0);
        @(negedge clk);
        start_access(16'h0011, 1'b0, '0, 2);
        #1 chk("ok_addr_fall", ext_ok, 0);
        finish_access(1'b1);

        // reset in the middle of a bus cycle
        @(negedge clk);
        start_access(16'h0300, 1'b0, '0, 5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        ext_rq = 1'b0;
        #1 chk("rst_mid_cs", mem_cs, 0);
        m_bv = 1'b0; m_din = '0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_din", ext_din, 0);
        @(posedge clk);

        for (int k = 0; k < 80; k++) begin
            logic [AW-1:0] a;
            logic we;
            int lat;
            a   = 16'h0400 + AW'($urandom_range(0, 3));
            we  = ($urandom_range(0, 9) < 3);
            lat = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, TOUT));
            access(a, we, DW'($urandom), lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
